mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline.
- Sequences each access as a multi-cycle request/acknowledge transaction.
- Drives the pipeline freeze controls: pc_o, if_id_o (1 = write, 0 = hold) and stall_o. These sit alongside the load-use hazard logic.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, max cycles waiting for mem_ack_i before abort; 0 disables the watchdog.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- if_req_i  input  1  fetch request, held until if_ack_o
- if_addr_i  input  ADDR_W  fetch address
- if_data_o  output  DATA_W  fetched instruction, valid with if_ack_o
- if_ack_o  output  1  one-cycle fetch completion pulse
- dm_req_i  input  1  data request, held until dm_ack_o
- dm_we_i  input  1  1 = store, 0 = load
- dm_addr_i  input  ADDR_W  data address
- dm_wdata_i  input  DATA_W  store data
- dm_rdata_o  output  DATA_W  load data, valid with dm_ack_o
- dm_ack_o  output  1  one-cycle data completion pulse
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_rdata_i  input  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  input  1  memory completion
- pc_o  output  1  PC write enable
- if_id_o  output  1  IF/ID register write enable
- stall_o  output  1  freeze ID/EX, EX/MEM, MEM/WB
- err_o  output  1  sticky watchdog error

Behaviour:
- Reset, synchronous on rst_i: state = IDLE, last_grant = FETCH (so data wins the first tie). All mem_* outputs 0. if_ack_o = dm_ack_o = 0. if_data_o = dm_rdata_o = 0. err_o = 0. Watchdog counter = 0.
- FSM states: IDLE, FETCH, DATA.
- IDLE arbitration:
  - Only dm_req_i -> DATA.
  - Only if_req_i -> FETCH.
  - Both pending -> grant the requester opposite to last_grant, then update last_grant.
  - No ack pulse may be high in the cycle a grant is evaluated. This prevents re-granting a request that has just been acknowledged.
- Grant latching: at the grant edge, latch address, we and wdata into mem_addr_o, mem_we_o and mem_wdata_o. Assert mem_req_o from the next cycle. Fetch grants force mem_we_o = 0.
- FETCH/DATA: hold mem_req_o and all mem_* outputs stable until mem_ack_i.
- On mem_ack_i:
  - Register mem_rdata_i into if_data_o (FETCH) or dm_rdata_o (DATA; loads only, stores leave dm_rdata_o unchanged).
  - Pulse the matching ack for exactly one cycle.
  - Drop mem_req_o.
  - Return to IDLE.
- Latency: request first seen at edge 0, mem_req_o high after edge 0, mem_ack_i sampled at edge k, requester ack high after edge k. Minimum is 2 cycles from request to ack.
- mem_ack_i is ignored in IDLE.
- Requester drops req before ack (protocol violation): the transaction still completes; the ack pulse is still generated and the consumer ignores it.
- Watchdog, when TIMEOUT_CYC > 0:
  - Counter clears on each grant and increments each cycle in FETCH/DATA without mem_ack_i.
  - When it reaches TIMEOUT_CYC: drop mem_req_o, pulse the requester ack with data 0, set err_o, go to IDLE.
  - err_o stays set until rst_i.
- Pipeline control, combinational from registered state:
  - fetch_wait = if_req_i & ~if_ack_o.
  - data_wait = dm_req_i & ~dm_ack_o.
  - stall_o = data_wait.
  - pc_o = if_id_o = ~(fetch_wait | data_wait).
  - During rst_i: stall_o = 0, pc_o = if_id_o = 1.
- Reset mid-transaction: the transaction is abandoned, mem_req_o = 0 after the reset edge, and no ack is issued. The memory side must tolerate a dropped request.
- Width rules: the watchdog counter is clog2(TIMEOUT_CYC+1) bits and saturates; it never wraps.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds three outputs: fetch_stall_cnt_o[31:0], data_stall_cnt_o[31:0], grant_cnt_o[31:0].
  - The stall counters count cycles with fetch_wait and data_wait high.
  - grant_cnt_o counts grants.
  - All saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Fetch only: if_req_i = 1, addr 0x0000_0040, memory acks 3 cycles after mem_req_o with 0x8C01_0004 -> mem_we_o = 0; if_ack_o pulses once with if_data_o = 0x8C01_0004; pc_o = 0 until that ack cycle.
- Simultaneous fetch and load after reset -> DATA granted first; stall_o = 1 until dm_ack_o; FETCH granted next; then alternation holds over 4 back-to-back contested pairs.
- Store: dm_we_i = 1, addr 0x100, wdata 0xDEAD_BEEF -> mem_we_o = 1, mem_wdata_o = 0xDEAD_BEEF held stable until mem_ack_i; dm_rdata_o unchanged.
- Watchdog with TIMEOUT_CYC = 4 and mem_ack_i tied 0 -> after 4 wait cycles mem_req_o = 0, dm_ack_o pulses with dm_rdata_o = 0, err_o = 1 and stays 1 until rst_i.
- rst_i asserted 1 cycle into a FETCH -> after the reset edge, state is IDLE, mem_req_o = 0, no if_ack_o pulse, a late mem_ack_i is ignored, and pc_o = 1 during reset.
- Stray mem_ack_i while IDLE -> no ack pulse and no data register change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/data arbiter for a single-ported memory with pipeline freeze, watchdog and optional MEM_ARB_PERF_CNT_EN perf counters
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              pc_o,
  output logic              if_id_o,
  output logic              stall_o,
  output logic              err_o
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_stall_cnt_o,
  output logic [31:0]       data_stall_cnt_o,
  output logic [31:0]       grant_cnt_o
`endif
);
  localparam int WD_W = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t state;
  logic last_data;
  logic pick_data;
  logic grant;
  logic timeout;
  logic fetch_wait;
  logic data_wait;
  logic [WD_W-1:0] wd_cnt;
  always_comb begin
    fetch_wait = if_req_i & ~if_ack_o;
    data_wait = dm_req_i & ~dm_ack_o;
    stall_o = ~rst_i & data_wait;
    pc_o = rst_i | ~(fetch_wait | data_wait);
    if_id_o = pc_o;
    pick_data = dm_req_i & (~if_req_i | ~last_data);
    grant = (state == IDLE) & ~if_ack_o & ~dm_ack_o & (if_req_i | dm_req_i);
    timeout = (TIMEOUT_CYC > 0) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last_data <= 1'b0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      if_data_o <= '0;
      dm_rdata_o <= '0;
      err_o <= 1'b0;
      wd_cnt <= '0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      if (grant) begin
        state <= pick_data ? DATA : FETCH;
        last_data <= pick_data;
        mem_req_o <= 1'b1;
        mem_we_o <= pick_data & dm_we_i;
        mem_addr_o <= pick_data ? dm_addr_i : if_addr_i;
        mem_wdata_o <= pick_data ? dm_wdata_i : '0;
        wd_cnt <= '0;
      end else if (state != IDLE && (mem_ack_i || timeout)) begin
        state <= IDLE;
        mem_req_o <= 1'b0;
        if_ack_o <= state == FETCH;
        dm_ack_o <= state == DATA;
        if (state == FETCH)
          if_data_o <= mem_ack_i ? mem_rdata_i : '0;
        else if (!mem_ack_i || !mem_we_o)
          dm_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
        if (!mem_ack_i) begin
          err_o <= 1'b1;
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else if (state != IDLE && TIMEOUT_CYC > 0) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_stall_cnt_o <= '0;
      data_stall_cnt_o <= '0;
      grant_cnt_o <= '0;
    end else begin
      if (fetch_wait && ~&fetch_stall_cnt_o) fetch_stall_cnt_o <= fetch_stall_cnt_o + 1'b1;
      if (data_wait && ~&data_stall_cnt_o) data_stall_cnt_o <= data_stall_cnt_o + 1'b1;
      if (grant && ~&grant_cnt_o) grant_cnt_o <= grant_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of mem_port_arbiter against a transaction-level memory and arbitration model
module tb_mem_port_arbiter;
  logic clk_i = 1'b0;
  logic rst_i;
  logic if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic if_ack_o;
  logic dm_req_i;
  logic dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic dm_ack_o;
  logic mem_req_o;
  logic mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic mem_ack_i;
  logic pc_o;
  logic if_id_o;
  logic stall_o;
  logic err_o;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  logic mem_en = 1'b0;
  logic lat_rand = 1'b0;
  int mem_lat = 1;
  int wcnt = 0;
  logic model_lg = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_idata = '0;
  logic grants [$];
  always #5 clk_i = ~clk_i;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .pc_o(pc_o), .if_id_o(if_id_o), .stall_o(stall_o), .err_o(err_o)
  );
  function automatic int idx(input logic [31:0] a);
    return int'(a[8:2]);
  endfunction
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (mem_en) begin
      if (mem_ack_i) mem_ack_i = 1'b0;
      else if (mem_req_o) begin
        wcnt++;
        if (wcnt >= mem_lat) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_we_o ? $urandom : mem[idx(mem_addr_o)];
          if (mem_we_o) mem[idx(mem_addr_o)] = mem_wdata_o;
          wcnt = 0;
          if (lat_rand) mem_lat = $urandom_range(3, 1);
        end
      end
    end
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    dm_we_i = 1'b0;
    mem_ack_i = 1'b0;
    wcnt = 0;
    tick();
    tick();
    rst_i = 1'b0;
    model_lg = 1'b0;
    exp_rdata = '0;
    exp_idata = '0;
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    if_req_i = 1'b1;
    dm_req_i = 1'b1;
    dm_we_i = 1'b0;
    if_addr_i = '0;
    dm_addr_i = 32'h100;
    dm_wdata_i = '0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    tick();
    tick();
    n_tests++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, expected all 0", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    n_tests++;
    if ({if_ack_o, dm_ack_o, err_o, if_data_o, dm_rdata_o} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_out: if_ack=%b dm_ack=%b err=%b if_data=%h dm_rdata=%h, expected all 0", if_ack_o, dm_ack_o, err_o, if_data_o, dm_rdata_o);
    end
    n_tests++;
    if ({pc_o, if_id_o, stall_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_pipe: pc/if_id/stall=%b%b%b, expected 110", pc_o, if_id_o, stall_o);
    end
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    rst_i = 1'b0;
    model_lg = 1'b0;
  endtask
  task automatic test_fetch_only();
    int ack_n = 0;
    int ack_t = -1;
    logic we_bad = 1'b0;
    mem_en = 1'b1;
    lat_rand = 1'b0;
    mem_lat = 3;
    wcnt = 0;
    mem[16] = 32'h8C01_0004;
    ref_mem[16] = 32'h8C01_0004;
    if_addr_i = 32'h40;
    if_req_i = 1'b1;
    #1;
    n_tests++;
    if (pc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_pc_start: pc=%b, expected 0", pc_o);
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (mem_req_o && mem_we_o !== 1'b0) we_bad = 1'b1;
      if (if_ack_o) begin
        ack_n++;
        ack_t = t;
        n_tests++;
        if (if_data_o !== 32'h8C01_0004 || pc_o !== 1'b1) begin
          n_fail++;
          $display("FAIL fetch_data: data=%h pc=%b, expected 8c010004 pc=1", if_data_o, pc_o);
        end
        exp_idata = 32'h8C01_0004;
        if_req_i = 1'b0;
      end else if (if_req_i) begin
        n_tests++;
        if (pc_o !== 1'b0 || if_id_o !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_pc_hold: pc=%b if_id=%b at t=%0d, expected 0", pc_o, if_id_o, t);
        end
      end
    end
    n_tests++;
    if (ack_n != 1 || ack_t != 4 || we_bad) begin
      n_fail++;
      $display("FAIL fetch_ack: pulses=%0d at t=%0d we_bad=%b, expected 1 pulse at t=4 we_bad=0", ack_n, ack_t, we_bad);
    end
  endtask
  task automatic run_traffic(input int ncyc, input int p_if, input int p_dm, input int p_st);
    logic pv_req;
    logic pv_if;
    logic pv_dm;
    logic pv_we;
    logic pv_mwe;
    logic [31:0] pv_ia;
    logic [31:0] pv_da;
    logic [31:0] pv_wd;
    logic [31:0] pv_ma;
    logic [31:0] pv_mw;
    logic kind;
    logic exp_kind;
    logic e_pc;
    logic drain;
    int c;
    grants.delete();
    mem_en = 1'b1;
    lat_rand = 1'b1;
    wcnt = 0;
    c = 0;
    pv_req = mem_req_o;
    pv_if = 1'b0;
    pv_dm = 1'b0;
    pv_we = 1'b0;
    pv_mwe = mem_we_o;
    pv_ia = '0;
    pv_da = '0;
    pv_wd = '0;
    pv_ma = mem_addr_o;
    pv_mw = mem_wdata_o;
    while (c < ncyc || ((if_req_i || dm_req_i || mem_req_o) && c < ncyc + 60)) begin
      drain = c >= ncyc;
      tick();
      c++;
      if (mem_req_o && !pv_req) begin
        kind = mem_addr_o[8];
        exp_kind = (pv_if && pv_dm) ? !model_lg : pv_dm;
        n_tests++;
        if (!(pv_if || pv_dm) || kind !== exp_kind) begin
          n_fail++;
          $display("FAIL grant_order: granted data=%b, expected data=%b (if_pend=%b dm_pend=%b)", kind, exp_kind, pv_if, pv_dm);
        end
        model_lg = kind;
        grants.push_back(kind);
        n_tests++;
        if (mem_addr_o !== (kind ? pv_da : pv_ia) || mem_we_o !== (kind & pv_we) || (kind && pv_we && mem_wdata_o !== pv_wd)) begin
          n_fail++;
          $display("FAIL grant_latch: addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h", mem_addr_o, mem_we_o, mem_wdata_o, kind ? pv_da : pv_ia, kind & pv_we, pv_wd);
        end
      end else if (!mem_req_o && !pv_req && (pv_if || pv_dm)) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_grant: mem_req=0, expected grant (if_pend=%b dm_pend=%b)", pv_if, pv_dm);
      end else if (mem_req_o && pv_req) begin
        n_tests++;
        if (mem_addr_o !== pv_ma || mem_we_o !== pv_mwe || mem_wdata_o !== pv_mw) begin
          n_fail++;
          $display("FAIL mem_hold: addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h", mem_addr_o, mem_we_o, mem_wdata_o, pv_ma, pv_mwe, pv_mw);
        end
      end
      if (if_ack_o) begin
        n_tests++;
        if (if_data_o !== ref_mem[idx(if_addr_i)]) begin
          n_fail++;
          $display("FAIL fetch_rdata: got %h, expected %h", if_data_o, ref_mem[idx(if_addr_i)]);
        end
        exp_idata = ref_mem[idx(if_addr_i)];
        if_req_i = 1'b0;
      end else if (!drain && !if_req_i && $urandom_range(99) < p_if) begin
        if_req_i = 1'b1;
        if_addr_i = $urandom & 32'hFC;
      end
      if (dm_ack_o) begin
        if (!dm_we_i) exp_rdata = ref_mem[idx(dm_addr_i)];
        else ref_mem[idx(dm_addr_i)] = dm_wdata_i;
        n_tests++;
        if (dm_rdata_o !== exp_rdata) begin
          n_fail++;
          $display("FAIL data_rdata: got %h, expected %h (store=%b)", dm_rdata_o, exp_rdata, dm_we_i);
        end
        dm_req_i = 1'b0;
      end else if (!drain && !dm_req_i && $urandom_range(99) < p_dm) begin
        dm_req_i = 1'b1;
        dm_we_i = $urandom_range(99) < p_st;
        dm_addr_i = 32'h100 | ($urandom & 32'hFC);
        dm_wdata_i = $urandom;
      end
      pv_req = mem_req_o;
      pv_ma = mem_addr_o;
      pv_mwe = mem_we_o;
      pv_mw = mem_wdata_o;
      pv_if = if_req_i && !if_ack_o && !dm_ack_o;
      pv_dm = dm_req_i && !if_ack_o && !dm_ack_o;
      pv_we = dm_we_i;
      pv_ia = if_addr_i;
      pv_da = dm_addr_i;
      pv_wd = dm_wdata_i;
      #1;
      e_pc = !((if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o));
      n_tests++;
      if (stall_o !== (dm_req_i && !dm_ack_o) || pc_o !== e_pc || if_id_o !== e_pc) begin
        n_fail++;
        $display("FAIL pipe_ctrl: stall=%b pc=%b if_id=%b, expected stall=%b pc=if_id=%b", stall_o, pc_o, if_id_o, dm_req_i && !dm_ack_o, e_pc);
      end
    end
    n_tests++;
    if (if_req_i || dm_req_i || mem_req_o) begin
      n_fail++;
      $display("FAIL drain_timeout: if_req=%b dm_req=%b mem_req=%b, expected all idle", if_req_i, dm_req_i, mem_req_o);
    end
  endtask
  task automatic test_contested();
    do_reset();
    run_traffic(60, 100, 100, 0);
    n_tests++;
    if (grants.size() < 8 || grants[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL contest_first: grants=%0d first_data=%b, expected >=8 and first_data=1", grants.size(), grants.size() > 0 ? grants[0] : 1'bx);
    end
    for (int i = 1; i < 8 && i < grants.size(); i++) begin
      n_tests++;
      if (grants[i] === grants[i-1]) begin
        n_fail++;
        $display("FAIL contest_alt: grant %0d data=%b, expected %b", i, grants[i], !grants[i-1]);
      end
    end
  endtask
  task automatic test_store();
    int ack_n = 0;
    logic held_bad = 1'b0;
    mem_en = 1'b1;
    lat_rand = 1'b0;
    mem_lat = 3;
    wcnt = 0;
    dm_we_i = 1'b1;
    dm_addr_i = 32'h100;
    dm_wdata_i = 32'hDEAD_BEEF;
    dm_req_i = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (mem_req_o && (mem_we_o !== 1'b1 || mem_wdata_o !== 32'hDEAD_BEEF || mem_addr_o !== 32'h100)) held_bad = 1'b1;
      if (dm_ack_o) begin
        ack_n++;
        n_tests++;
        if (dm_rdata_o !== exp_rdata) begin
          n_fail++;
          $display("FAIL store_rdata: got %h, expected unchanged %h", dm_rdata_o, exp_rdata);
        end
        dm_req_i = 1'b0;
      end
    end
    n_tests++;
    if (ack_n != 1 || held_bad || mem[64] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL store_write: acks=%0d held_bad=%b mem=%h, expected 1 ack held_bad=0 mem=deadbeef", ack_n, held_bad, mem[64]);
    end
    ref_mem[64] = 32'hDEAD_BEEF;
    dm_we_i = 1'b0;
  endtask
  task automatic test_watchdog();
    int req_n = 0;
    int ack_n = 0;
    mem_en = 1'b0;
    mem_ack_i = 1'b0;
    dm_we_i = 1'b0;
    dm_addr_i = 32'h104;
    dm_req_i = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (mem_req_o) req_n++;
      if (dm_ack_o) begin
        ack_n++;
        n_tests++;
        if (mem_req_o !== 1'b0 || dm_rdata_o !== 32'h0 || err_o !== 1'b1 || req_n != 4) begin
          n_fail++;
          $display("FAIL wdog_abort: mem_req=%b rdata=%h err=%b req_cycles=%0d, expected 0/0/1/4", mem_req_o, dm_rdata_o, err_o, req_n);
        end
        dm_req_i = 1'b0;
      end
    end
    exp_rdata = '0;
    n_tests++;
    if (ack_n != 1 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_sticky: acks=%0d err=%b, expected 1 ack err=1", ack_n, err_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_lg = 1'b0;
    exp_idata = '0;
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_clear: err=%b, expected 0 after reset", err_o);
    end
  endtask
  task automatic test_reset_mid();
    mem_en = 1'b0;
    mem_ack_i = 1'b0;
    if_addr_i = 32'h80;
    if_req_i = 1'b1;
    tick();
    n_tests++;
    if (mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_grant: mem_req=%b, expected 1", mem_req_o);
    end
    rst_i = 1'b1;
    dm_req_i = 1'b1;
    #1;
    n_tests++;
    if (pc_o !== 1'b1 || if_id_o !== 1'b1 || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_pipe: pc=%b if_id=%b stall=%b, expected 1/1/0", pc_o, if_id_o, stall_o);
    end
    tick();
    n_tests++;
    if (mem_req_o !== 1'b0 || if_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_abandon: mem_req=%b if_ack=%b, expected 0/0", mem_req_o, if_ack_o);
    end
    rst_i = 1'b0;
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    model_lg = 1'b0;
    exp_idata = '0;
    exp_rdata = '0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    tick();
    n_tests++;
    if (if_ack_o !== 1'b0 || if_data_o !== 32'h0 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_late_ack: if_ack=%b if_data=%h mem_req=%b, expected 0/0/0", if_ack_o, if_data_o, mem_req_o);
    end
    mem_ack_i = 1'b0;
    tick();
    n_tests++;
    if (if_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_no_ack: if_ack=%b, expected 0", if_ack_o);
    end
  endtask
  task automatic test_random();
    do_reset();
    run_traffic(800, 30, 30, 40);
  endtask
  task automatic test_stray_ack();
    mem_en = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFF_0000;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_tests++;
      if (if_ack_o !== 1'b0 || dm_ack_o !== 1'b0 || mem_req_o !== 1'b0 || if_data_o !== exp_idata || dm_rdata_o !== exp_rdata) begin
        n_fail++;
        $display("FAIL stray_ack: if_ack=%b dm_ack=%b mem_req=%b if_data=%h dm_rdata=%h, expected 0/0/0 %h %h", if_ack_o, dm_ack_o, mem_req_o, if_data_o, dm_rdata_o, exp_idata, exp_rdata);
      end
    end
    mem_ack_i = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at 1ms, expected completion");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom | 32'h1;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_fetch_only();
    test_contested();
    test_store();
    test_watchdog();
    test_reset_mid();
    test_random();
    test_stray_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
